vga_timing_generator: RTL and testbench

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

---
 rtl/vga_timing_generator.sv | 75 +++++++
 tb/tb_vga_timing_generator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running pixel/line counters with sync, active-area,
// clamped coordinates and an end-of-frame strobe decoded from the counters.
module vga_timing_generator #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       screenEnd,
  output logic       active,
  output logic       hSync,
  output logic       vSync,
  output logic [9:0] x,
  output logic [8:0] y
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS       = 10'(WIDTH);
  localparam logic [9:0] V_VIS       = 10'(HEIGHT);
  localparam logic [9:0] H_SYNC_BEG  = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] H_SYNC_END  = 10'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(HEIGHT + V_FRONT);
  localparam logic [9:0] V_SYNC_END  = 10'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [8:0] Y_MAX       = 9'(HEIGHT - 1);

  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hWrap;

  // During blanking the line index is held at the last visible line so that
  // downstream address logic never sees a wrapped or aliased row.
  function automatic logic [8:0] clampLine(input logic [9:0] line);
    if (line < V_VIS) return line[8:0];
    else              return Y_MAX;
  endfunction

  assign hWrap = (hCount == H_LAST);

  // Pixel counter: 0..H_TOTAL-1, wraps at end of line.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset)      hCount <= '0;
    else if (hWrap) hCount <= '0;
    else            hCount <= hCount + 10'd1;
  end

  // Line counter: advances once per line wrap, 0..V_TOTAL-1.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) vCount <= '0;
    else if (hWrap) begin
      if (vCount == V_LAST) vCount <= '0;
      else                  vCount <= vCount + 10'd1;
    end
  end

  // Output decode: pure functions of the two counter registers.
  always_comb begin
    x         = hCount;
    y         = clampLine(vCount);
    active    = (hCount < H_VIS) && (vCount < V_VIS);
    hSync     = !((hCount >= H_SYNC_BEG) && (hCount < H_SYNC_END));
    vSync     = !((vCount >= V_SYNC_BEG) && (vCount < V_SYNC_END));
    screenEnd = hWrap && (vCount == V_LAST);
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a full-size instance for line-level timing
// and a reduced-geometry instance so whole frames fit in a short run.
module tb_vga_timing_generator;

  // Reduced geometry: 80 clocks per line, 57 lines per frame.
  localparam int SW = 64, SH = 48, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVF = 3, SVS = 2, SVB = 4;
  localparam int SHT = SW + SHF + SHS + SHB;
  localparam int SVT = SH + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;
  localparam int FHT = 800, FVT = 525;

  typedef struct { int x; int y; int act; int hs; int vs; int se; } outs_t;
  typedef struct { outs_t f; outs_t s; int fLine; } exp_t;

  logic       clk25 = 1'b0;
  logic       reset = 1'b0;
  logic       fSe, fAct, fHs, fVs, sSe, sAct, sHs, sVs;
  logic [9:0] fX, sX;
  logic [8:0] fY, sY;

  int nAsserts = 0;
  int nFails   = 0;
  int fh = 0, fv = 0, sh = 0, sv = 0;
  int relEdges = 0;
  int phase = 0;
  int hsLowCnt = 0, hsFirstX = -1, hsLastX = -1, actCnt0 = 0, vsLowCntS = 0;
  exp_t expQ[$];
  int   seEdges[$];

  vga_timing_generator dutFull (
    .clk25(clk25), .reset(reset), .screenEnd(fSe), .active(fAct),
    .hSync(fHs), .vSync(fVs), .x(fX), .y(fY)
  );

  vga_timing_generator #(
    .WIDTH(SW), .HEIGHT(SH), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dutSmall (
    .clk25(clk25), .reset(reset), .screenEnd(sSe), .active(sAct),
    .hSync(sHs), .vSync(sVs), .x(sX), .y(sY)
  );

  always #5 clk25 = ~clk25;

  task automatic checkVal(input string tag, input int obs, input int exp);
    nAsserts++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic outs_t expOuts(input int h, input int v, input int w, input int ht,
                                    input int hf, input int hs, input int ht2, input int vt,
                                    input int vf, input int vs);
    outs_t o;
    o.x   = h;
    o.y   = (v < ht) ? v : ht - 1;
    o.act = (h < w && v < ht) ? 1 : 0;
    o.hs  = (h >= w + hf && h < w + hf + hs) ? 0 : 1;
    o.vs  = (v >= ht + vf && v < ht + vf + vs) ? 0 : 1;
    o.se  = (h == ht2 - 1 && v == vt - 1) ? 1 : 0;
    return o;
  endfunction

  function automatic exp_t buildExp();
    exp_t e;
    e.f = expOuts(fh, fv, 640, 480, 16, 96, FHT, FVT, 10, 2);
    e.s = expOuts(sh, sv, SW, SH, SHF, SHS, SHT, SVT, SVF, SVS);
    e.fLine = fv;
    return e;
  endfunction

  // One clock edge: advance the reference counters and queue the expectation.
  task automatic tick();
    @(posedge clk25);
    if (!reset) begin
      relEdges++;
      if (fh == FHT - 1) begin fh = 0; fv = (fv == FVT - 1) ? 0 : fv + 1; end
      else fh++;
      if (sh == SHT - 1) begin sh = 0; sv = (sv == SVT - 1) ? 0 : sv + 1; end
      else sh++;
    end
    expQ.push_back(buildExp());
  endtask

  task automatic checkResetOuts(input string who, input logic [9:0] ox, input logic [8:0] oy,
                                input logic oa, input logic ohs, input logic ovs, input logic ose);
    checkVal({who, "RstX"}, int'(ox), 0);
    checkVal({who, "RstY"}, int'(oy), 0);
    checkVal({who, "RstActive"}, int'(oa), 1);
    checkVal({who, "RstHSync"}, int'(ohs), 1);
    checkVal({who, "RstVSync"}, int'(ovs), 1);
    checkVal({who, "RstScreenEnd"}, int'(ose), 0);
  endtask

  // Scoreboard: compare both instances against queued expectations away from the edge.
  always @(negedge clk25) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkVal("fullX", int'(fX), e.f.x);
      checkVal("fullY", int'(fY), e.f.y);
      checkVal("fullActive", int'(fAct), e.f.act);
      checkVal("fullHSync", int'(fHs), e.f.hs);
      checkVal("fullVSync", int'(fVs), e.f.vs);
      checkVal("fullScreenEnd", int'(fSe), e.f.se);
      checkVal("smallX", int'(sX), e.s.x);
      checkVal("smallY", int'(sY), e.s.y);
      checkVal("smallActive", int'(sAct), e.s.act);
      checkVal("smallHSync", int'(sHs), e.s.hs);
      checkVal("smallVSync", int'(sVs), e.s.vs);
      checkVal("smallScreenEnd", int'(sSe), e.s.se);
      if (phase == 1 && e.fLine == 0) begin
        if (fAct) actCnt0++;
        if (!fHs) begin
          hsLowCnt++;
          if (hsFirstX < 0) hsFirstX = int'(fX);
          hsLastX = int'(fX);
        end
      end
      if (phase == 1 && relEdges < SFRAME && !sVs) vsLowCntS++;
    end
    if (phase > 0 && sSe) seEdges.push_back(relEdges);
  end

  initial begin
    // Reset asserted before any clock edge: outputs must settle immediately.
    #2 reset = 1'b1;
    #1;
    checkResetOuts("full", fX, fY, fAct, fHs, fVs, fSe);
    checkResetOuts("small", sX, sY, sAct, sHs, sVs, sSe);
    repeat (3) tick();
    @(negedge clk25);
    #2 reset = 1'b0;
    fh = 0; fv = 0; sh = 0; sv = 0; relEdges = 0;
    phase = 1;
    #1;
    checkVal("relFullX", int'(fX), 0);
    checkVal("relFullActive", int'(fAct), 1);

    // Two reduced frames plus margin; full instance covers its first lines.
    for (int i = 0; i < 2 * SFRAME + 10; i++) tick();
    @(negedge clk25);
    #1;
    phase = 2;
    checkVal("line0ActiveCount", actCnt0, 639);   // x=0 was checked at release
    checkVal("line0HSyncLowCount", hsLowCnt, 96);
    checkVal("line0HSyncFirstX", hsFirstX, 656);
    checkVal("line0HSyncLastX", hsLastX, 751);
    checkVal("frameVSyncLowCount", vsLowCntS, SVS * SHT);
    checkVal("screenEndPulses", seEdges.size(), 2);
    if (seEdges.size() >= 2) begin
      checkVal("screenEnd1Edge", seEdges[0], SFRAME - 1);
      checkVal("screenEnd2Edge", seEdges[1], 2 * SFRAME - 1);
    end

    // Advance into the vertical sync of the third reduced frame, then pulse reset.
    for (int i = 0; i < SFRAME && !(sv == SH + SVF && sh == 5); i++) tick();
    @(negedge clk25);
    checkVal("smallVSyncLowBeforeRst", int'(sVs), 0);
    #2 reset = 1'b1;
    fh = 0; fv = 0; sh = 0; sv = 0;
    #1;
    checkResetOuts("fullMid", fX, fY, fAct, fHs, fVs, fSe);
    checkResetOuts("smallMid", sX, sY, sAct, sHs, sVs, sSe);
    repeat (2) tick();
    @(negedge clk25);
    #2 reset = 1'b0;
    relEdges = 0;
    seEdges.delete();
    phase = 3;
    for (int i = 0; i < SFRAME + 5; i++) tick();
    @(negedge clk25);
    #1;
    checkVal("postRstScreenEndPulses", seEdges.size(), 1);
    if (seEdges.size() >= 1) checkVal("postRstScreenEndEdge", seEdges[0], SFRAME - 1);
    checkVal("scoreboardDrained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
